// File: rtl/sha_block_mem.sv
// sha_block_mem: ping-pong message-block memory for the sha256 core.
// A loader fills one bank while the core reads the other.
module sha_block_mem #(
  parameter int RD_LATENCY = 1,
  parameter int WORDS      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_vld,
  output logic        wr_rdy,
  input  logic [31:0] wr_data,
  input  logic        mem_addr_vld,
  input  logic [31:0] mem_addr,
  output logic        mem_data_vld,
  output logic [31:0] mem_data,
  output logic        mem_err,
  output logic        blk_vld,
  input  logic        blk_done,
  output logic [1:0]  blk_count
);

  localparam int IW = $clog2(WORDS);

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          rd_bank_q, rd_bank_d;
  logic          wr_rdy_q, wr_rdy_d;

  logic [31:0]   ram_q [2][WORDS];

  logic          wr_fire;
  logic          wr_last;
  logic          rd_rel;

  logic [IW-1:0] rd_idx;
  logic          rd_err;
  logic [31:0]   rd_word;

  logic          pv_d [RD_LATENCY];
  logic [31:0]   pd_d [RD_LATENCY];
  logic          pe_d [RD_LATENCY];
  logic          pv_q [RD_LATENCY];
  logic [31:0]   pd_q [RD_LATENCY];
  logic          pe_q [RD_LATENCY];

  // Handshake and bank-release qualification
  always_comb begin
    wr_fire = wr_vld & wr_rdy_q;
    wr_last = wr_fire & (wr_idx_q == IW'(WORDS - 1));
    rd_rel  = blk_done & full_q[rd_bank_q];
  end

  // Bank bookkeeping next state; write and release never hit one bank
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      wr_idx_d = wr_idx_q + IW'(1);
    end
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      wr_idx_d          = '0;
    end
    if (rd_rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    wr_rdy_d = ~full_d[wr_bank_d];
  end

  // Bank bookkeeping state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      wr_rdy_q  <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      wr_rdy_q  <= wr_rdy_d;
    end
  end

  // Bank storage, not reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      ram_q[wr_bank_q][wr_idx_q] <= wr_data;
    end
  end

  // Request decode against pre-update bank state
  always_comb begin
    rd_idx  = mem_addr[IW+1:2];
    rd_err  = (|mem_addr[1:0]) | (|mem_addr[31:IW+2]) | ~full_q[rd_bank_q];
    rd_word = rd_err ? 32'h0 : ram_q[rd_bank_q][rd_idx];
  end

  // Pipeline stage inputs: stage 0 takes the request, others shift
  always_comb begin
    for (int k = 0; k < RD_LATENCY; k++) begin
      if (k == 0) begin
        pv_d[k] = mem_addr_vld;
        pd_d[k] = rd_word;
        pe_d[k] = rd_err;
      end else begin
        pv_d[k] = pv_q[k-1];
        pd_d[k] = pd_q[k-1];
        pe_d[k] = pe_q[k-1];
      end
    end
  end

  // Pipeline registers; payload only moves with a valid so it holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        pv_q[k] <= 1'b0;
        pd_q[k] <= '0;
        pe_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        pv_q[k] <= pv_d[k];
        if (pv_d[k]) begin
          pd_q[k] <= pd_d[k];
          pe_q[k] <= pe_d[k];
        end
      end
    end
  end

  // Outputs straight from state
  always_comb begin
    wr_rdy       = wr_rdy_q;
    blk_vld      = full_q[rd_bank_q];
    blk_count    = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    mem_data_vld = pv_q[RD_LATENCY-1];
    mem_data     = pd_q[RD_LATENCY-1];
    mem_err      = pe_q[RD_LATENCY-1];
  end

endmodule
